// File: rtl/ram_dump_tx_pkg.sv
// Shared definitions for the RAM dump serial transmitter.
// The top-level FSM and the UART serializer both import this package.
package ram_dump_tx_pkg;

  // 8N1 frame: start bit, eight data bits, stop bit.
  localparam int FRAME_BITS = 10;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_BAUD_DIV = 434;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    CSUM  = 3'd4
  } dump_state_t;

  // Line image of one frame, bit 0 goes on the wire first.
  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/ram_dump_tx_uart_tx_serializer.sv
// 8N1 UART transmit serializer.
// A load is taken only while ready is high. ready is also high in the final
// cycle of a stop bit, so the controller can react on the same edge that
// ends the frame and keep the byte-to-byte period tight.
module uart_tx_serializer
  import ram_dump_tx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       ser_out
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  active;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bit_cnt;
  logic [BW-1:0]         baud_cnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  last_tick;

  assign frame     = uart_frame(data_in);
  assign last_tick = active && (baud_cnt == '0) && (bit_cnt == '0);
  assign ready     = !active || last_tick;

  // Baud and bit down-counters; the line bit is registered so it never glitches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active   <= 1'b0;
      shift    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      ser_out  <= 1'b1;
    end else if (load && ready) begin
      // The start bit goes straight to the line; the rest waits in shift.
      active   <= 1'b1;
      shift    <= {1'b1, frame[FRAME_BITS-1:1]};
      ser_out  <= frame[0];
      bit_cnt  <= BIT_LAST;
      baud_cnt <= BAUD_LAST;
    end else if (active) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else if (bit_cnt == '0) begin
        active  <= 1'b0;
        ser_out <= 1'b1;
      end else begin
        baud_cnt <= BAUD_LAST;
        bit_cnt  <= bit_cnt - 1'b1;
        ser_out  <= shift[0];
        shift    <= {1'b1, shift[FRAME_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// Debug RAM read-back engine: reads a window of the RAM through a spare
// read port and sends each byte out as an 8N1 frame.
// Optional feature macro: RAM_DUMP_CHECKSUM_EN appends a two's-complement
// checksum trailer frame after the last data byte.
//
// state | meaning
// IDLE  | waiting for start; length==0 completes immediately
// FETCH | ram_en high for one cycle at the current address
// WAIT  | RAM data valid, loaded into the serializer
// SEND  | frame on the line, wait for its stop bit to finish
// CSUM  | trailer frame (checksum build only), no RAM access
module ram_dump_tx
  import ram_dump_tx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              ser_out
);

  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_t       state;
  logic [ADDR_W:0]   count;
  logic              ser_load;
  logic              ser_ready;
  logic [7:0]        ser_data;

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [7:0]        sum;
  logic              csum_loaded;

  assign ser_load = (state == WAIT) || ((state == CSUM) && !csum_loaded);
  assign ser_data = (state == CSUM) ? ((~sum) + 8'd1) : ram_data;
`else
  assign ser_load = (state == WAIT);
  assign ser_data = ram_data;
`endif

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ser_load),
    .data_in (ser_data),
    .ready   (ser_ready),
    .ser_out (ser_out)
  );

  // Sequencing FSM: owns the address, the remaining byte count and the checksum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      count       <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum         <= '0;
      csum_loaded <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      ram_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              ram_addr <= start_addr;
              count    <= length;
              ram_en   <= 1'b1;
              busy     <= 1'b1;
              state    <= FETCH;
`ifdef RAM_DUMP_CHECKSUM_EN
              sum      <= '0;
`endif
            end
          end
        end

        FETCH: state <= WAIT;

        WAIT: begin
`ifdef RAM_DUMP_CHECKSUM_EN
          sum   <= sum + ram_data;
`endif
          state <= SEND;
        end

        SEND: begin
          if (ser_ready) begin
            count <= count - 1'b1;
            if (count != COUNT_ONE) begin
              // Address wraps naturally at the top of the RAM.
              ram_addr <= ram_addr + 1'b1;
              ram_en   <= 1'b1;
              state    <= FETCH;
            end else begin
`ifdef RAM_DUMP_CHECKSUM_EN
              csum_loaded <= 1'b0;
              state       <= CSUM;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
`endif
            end
          end
        end

`ifdef RAM_DUMP_CHECKSUM_EN
        CSUM: begin
          if (!csum_loaded) begin
            csum_loaded <= 1'b1;
          end else if (ser_ready) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Self-checking bench for ram_dump_tx with BAUD_DIV=4.
// Expected bytes are pushed to a scoreboard when a dump is started; a
// negedge monitor decodes frames from ser_out and logs ram_en/done events.
module tb_ram_dump_tx;

  localparam int BAUD_DIV  = 4;
  localparam int ADDR_W    = 10;
  localparam int FRAME_CYC = 10 * BAUD_DIV;
  localparam int BYTE_CYC  = FRAME_CYC + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done, ram_en, ser_out;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [7:0] data;
    int         st;
    bit         ok;
  } rx_t;

  rx_t             rx_q[$];
  logic [7:0]      exp_q[$];
  int              en_cyc_q[$];
  logic [ADDR_W-1:0] en_addr_q[$];
  int              done_q[$];
  bit              mon_en = 1'b0;
  bit              in_frame = 1'b0;
  int              fs = 0;
  int              ser_low_cnt = 0;
  logic            line_s [FRAME_CYC];
  rx_t             mon_r;

  ram_dump_tx #(
    .BAUD_DIV (BAUD_DIV),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ser_out    (ser_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  always @(negedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_en) begin
      en_cyc_q.push_back(cyc);
      en_addr_q.push_back(ram_addr);
    end
    if (done) done_q.push_back(cyc);
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (ser_out !== 1'b1) ser_low_cnt++;
      if (!in_frame && ser_out === 1'b0) begin
        in_frame = 1'b1;
        fs = cyc;
      end
      if (in_frame) begin
        line_s[cyc - fs] = ser_out;
        if (cyc - fs == FRAME_CYC - 1) begin
          mon_r.st = fs;
          mon_r.ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < BAUD_DIV; j++)
              if (line_s[k*BAUD_DIV + j] !== line_s[k*BAUD_DIV]) mon_r.ok = 1'b0;
          if (line_s[0] !== 1'b0) mon_r.ok = 1'b0;
          if (line_s[9*BAUD_DIV] !== 1'b1) mon_r.ok = 1'b0;
          for (int b = 0; b < 8; b++) mon_r.data[b] = line_s[(b+1)*BAUD_DIV];
          rx_q.push_back(mon_r);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    exp_q.delete();
    en_cyc_q.delete();
    en_addr_q.delete();
    done_q.delete();
    ser_low_cnt = 0;
  endtask

  task automatic push_expected(input logic [ADDR_W-1:0] a, input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[ADDR_W'(int'(a) + i)]);
      s = s + mem[ADDR_W'(int'(a) + i)];
    end
`ifdef RAM_DUMP_CHECKSUM_EN
    if (n > 0) exp_q.push_back(8'h00 - s);
`endif
  endtask

  function automatic int expected_done(input int t0, input int n);
    int d;
    d = t0 + 1 + BYTE_CYC * n;
`ifdef RAM_DUMP_CHECKSUM_EN
    if (n > 0) d = d + FRAME_CYC + 1;
`endif
    return d;
  endfunction

  // Drive a one-cycle start; returns at the negedge of cycle 1.
  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n,
                          output int t0);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    length = n;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    start_addr = ADDR_W'($urandom);
    length = (ADDR_W+1)'($urandom);
  endtask

  task automatic wait_done(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b ram_en=%b, expected 0 0 0", busy, done, ram_en);
    end
    checks++;
    if (ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: ram_addr=%h, expected 000", ram_addr);
    end
    checks++;
    if (ser_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_line: ser_out=%b, expected 1", ser_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int t0;
    bit to;
    rx_t r;
    logic [7:0] e;
    clear_logs();
    mem[10'h010] = 8'hA5;
    push_expected(10'h010, 1);
    do_start(10'h010, 11'd1, t0);
    checks++;
    if (busy !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 10'h010) begin
      errors++;
      $display("FAIL single_cycle1: busy=%b ram_en=%b addr=%h, expected 1 1 010", busy, ram_en, ram_addr);
    end
    wait_done(400, to);
    checks++;
    if (to || busy !== 1'b0 || cyc !== expected_done(t0, 1)) begin
      errors++;
      $display("FAIL single_done: timeout=%0d busy=%b cycle=%0d, expected cycle %0d busy 0",
               to, busy, cyc - t0, expected_done(t0, 1) - t0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() == 0 || rx_q[0].st !== t0 + 3) begin
      errors++;
      $display("FAIL single_start_bit: frames=%0d first start cycle=%0d, expected 3",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0].st - t0 : -1);
    end
    checks++;
    if (done_q.size() != 1 || en_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL single_events: done pulses=%0d ram_en cycles=%0d, expected 1 1",
               done_q.size(), en_cyc_q.size());
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_frames: got %0d frames, expected %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (!r.ok || r.data !== e) begin
        errors++;
        $display("FAIL single_byte: got %h (framing ok=%0d), expected %h", r.data, r.ok, e);
      end
    end
  endtask

  task automatic test_wrap();
    int t0;
    bit to;
    rx_t r;
    logic [7:0] e;
    logic [ADDR_W-1:0] exp_addr [3];
    clear_logs();
    mem[10'h3FE] = 8'h11;
    mem[10'h3FF] = 8'h22;
    mem[10'h000] = 8'h33;
    exp_addr[0] = 10'h3FE;
    exp_addr[1] = 10'h3FF;
    exp_addr[2] = 10'h000;
    push_expected(10'h3FE, 3);
    do_start(10'h3FE, 11'd3, t0);
    wait_done(800, to);
    checks++;
    if (to || cyc !== expected_done(t0, 3)) begin
      errors++;
      $display("FAIL wrap_done: timeout=%0d cycle=%0d, expected %0d",
               to, cyc - t0, expected_done(t0, 3) - t0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL wrap_fetches: got %0d ram_en cycles, expected 3", en_cyc_q.size());
    end
    for (int i = 0; i < 3 && i < en_cyc_q.size(); i++) begin
      checks++;
      if (en_addr_q[i] !== exp_addr[i] || en_cyc_q[i] !== t0 + 1 + BYTE_CYC * i) begin
        errors++;
        $display("FAIL wrap_fetch%0d: addr=%h cycle=%0d, expected addr %h cycle %0d",
                 i, en_addr_q[i], en_cyc_q[i] - t0, exp_addr[i], 1 + BYTE_CYC * i);
      end
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_frames: got %0d frames, expected %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (!r.ok || r.data !== e) begin
        errors++;
        $display("FAIL wrap_byte: got %h (framing ok=%0d), expected %h", r.data, r.ok, e);
      end
    end
  endtask

  task automatic test_zero_length();
    int t0;
    bit busy_seen;
    clear_logs();
    do_start(10'h123, 11'd0, t0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_cycle1: done=%b busy=%b, expected 1 0", done, busy);
    end
    busy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen || en_cyc_q.size() != 0 || ser_low_cnt != 0 || done_q.size() != 1) begin
      errors++;
      $display("FAIL zero_quiet: busy_seen=%0d ram_en=%0d line_low=%0d done=%0d, expected 0 0 0 1",
               busy_seen, en_cyc_q.size(), ser_low_cnt, done_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int t0;
    bit to;
    rx_t r;
    logic [7:0] e;
    clear_logs();
    mem[10'h020] = 8'h3C;
    mem[10'h050] = 8'hEE;
    push_expected(10'h020, 1);
    do_start(10'h020, 11'd1, t0);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1;
    start_addr = 10'h050;
    length = 11'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, to);
    checks++;
    if (to || cyc !== expected_done(t0, 1)) begin
      errors++;
      $display("FAIL ignore_done: timeout=%0d cycle=%0d, expected %0d",
               to, cyc - t0, expected_done(t0, 1) - t0);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (done_q.size() != 1 || en_cyc_q.size() != 1 || rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ignore_events: done=%0d ram_en=%0d frames=%0d, expected 1 1 %0d",
               done_q.size(), en_cyc_q.size(), rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (!r.ok || r.data !== e) begin
        errors++;
        $display("FAIL ignore_byte: got %h (framing ok=%0d), expected %h", r.data, r.ok, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t0;
    bit to;
    rx_t r;
    logic [7:0] e;
    clear_logs();
    mem[10'h030] = 8'h5A;
    mem[10'h031] = 8'h77;
    do_start(10'h030, 11'd2, t0);
    while (cyc < t0 + 19) @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: ser_out=%b busy=%b ram_en=%b, expected 1 0 0",
               ser_out, busy, ram_en);
    end
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    clear_logs();
    mem[10'h040] = 8'h96;
    push_expected(10'h040, 1);
    do_start(10'h040, 11'd1, t0);
    wait_done(400, to);
    checks++;
    if (to || cyc !== expected_done(t0, 1)) begin
      errors++;
      $display("FAIL midreset_restart_done: timeout=%0d cycle=%0d, expected %0d",
               to, cyc - t0, expected_done(t0, 1) - t0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size() || en_addr_q.size() != 1 || en_addr_q[0] !== 10'h040) begin
      errors++;
      $display("FAIL midreset_restart_events: frames=%0d fetches=%0d, expected %0d frames, 1 fetch at 040",
               rx_q.size(), en_addr_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (!r.ok || r.data !== e) begin
        errors++;
        $display("FAIL midreset_byte: got %h (framing ok=%0d), expected %h", r.data, r.ok, e);
      end
    end
  endtask

  task automatic test_multi_byte();
    int t0;
    bit to;
    rx_t r;
    logic [7:0] e;
    int last_st;
    clear_logs();
    mem[10'h100] = 8'h01;
    mem[10'h101] = 8'h02;
    mem[10'h102] = 8'h03;
    push_expected(10'h100, 3);
    do_start(10'h100, 11'd3, t0);
    wait_done(800, to);
    checks++;
    if (to || cyc !== expected_done(t0, 3)) begin
      errors++;
      $display("FAIL multi_done: timeout=%0d cycle=%0d, expected %0d",
               to, cyc - t0, expected_done(t0, 3) - t0);
    end
    repeat (3) @(negedge clk);
    last_st = (rx_q.size() > 0) ? rx_q[rx_q.size()-1].st : -1000;
    checks++;
    if (done_q.size() != 1 || done_q[0] !== last_st + FRAME_CYC) begin
      errors++;
      $display("FAIL multi_done_after_stop: done pulses=%0d done cycle=%0d, expected 1 pulse at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1, last_st + FRAME_CYC - t0);
    end
    checks++;
    if (rx_q.size() != exp_q.size() || en_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL multi_frames: frames=%0d fetches=%0d, expected %0d frames 3 fetches",
               rx_q.size(), en_cyc_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (!r.ok || r.data !== e) begin
        errors++;
        $display("FAIL multi_byte: got %h (framing ok=%0d), expected %h", r.data, r.ok, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    test_reset();
    test_single();
    test_wrap();
    test_zero_length();
    test_ignore_start();
    test_mid_reset();
    test_multi_byte();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
